// File: rtl/letter_uart_tx.sv
// Small synchronous FIFO with a write that may land in the same cycle as a read.
// Latency: a written entry is visible at the read side one cycle after the write edge.
// Backpressure: wr_rdy is low only when full and no read is taken on the same edge.
module fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    input  logic         rd_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          push;
    logic          pop;

    // The count runs 0..DEPTH exactly, so full and empty never alias.
    assign full   = (cnt == (AW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign rd_vld = !empty;
    assign rd_dat = mem[rd_ptr];
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_rdy = !full || rd_rdy;
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_vld && rd_rdy;

    // Storage array; contents need no reset because the count guards them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// Letter codes to uppercase ASCII, queued and sent as UART 8N1 frames.
// Latency: TX start bit begins one cycle after the load edge when idle; frame is 10*CPB cycles.
// Backpressure: none toward the core; loads into a full queue are dropped and flagged in OVF.
module letter_uart_tx #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600,
    parameter int DEPTH    = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [4:0] LET,
    input  logic       LD,
    output logic       TX,
    output logic       BUSY,
    output logic       EMPTY,
    output logic       FULL,
    output logic       OVF
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic [7:0]    let_byte;
    logic          wr_rdy;
    logic          rd_rdy;
    logic          rd_vld;
    logic [7:0]    rd_dat;
    logic          baud_last;

    // Out-of-range codes print as '?' so a bad code is visible on the terminal.
    assign let_byte  = (LET < 5'd26) ? (8'h41 + {3'b000, LET}) : 8'h3F;
    assign rd_rdy    = (state_q == IDLE);
    assign baud_last = (baud_q == CW'(CPB - 1));

    fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_vld (LD),
        .wr_dat (let_byte),
        .wr_rdy (wr_rdy),
        .rd_rdy (rd_rdy),
        .rd_vld (rd_vld),
        .rd_dat (rd_dat),
        .full   (FULL),
        .empty  (EMPTY)
    );

    // Sticky overflow flag: any load refused by the queue.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OVF <= 1'b0;
        end else if (LD && !wr_rdy) begin
            OVF <= 1'b1;
        end
    end

    // Frame state, counters, shift register and the registered TX line.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx_d is the line level for the cycle being entered.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        case (state_q)
            IDLE: begin
                if (rd_vld) begin
                    shift_d = rd_dat;
                    baud_d  = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                    tx_d   = 1'b0;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[bit_q + 3'd1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                    tx_d   = shift_q[bit_q];
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign TX   = tx_q;
    assign BUSY = (state_q != IDLE);
endmodule
